// File: rtl/bellek_hakemi.sv
// bellek_hakemi: arbitrates the instruction-cache refill port and the core
// data port onto a single shared memory master (iomem) port.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   ib_valid_i, ib_addr_i instruction refill request and address
//   ib_ready_o            one-cycle completion pulse for the refill
//   ib_rdata_o            refill word; held until the next instruction completion
//   l1v_sec_n_i           data request select (active low)
//   l1v_yaz_gecerli_i     1 = write, 0 = read
//   l1v_adr_i             data address
//   l1v_veri_maske_i      byte write mask
//   l1v_veri_i            write data
//   l1v_veri_o            read word; held until the next data read completion
//   l1v_durdur_o          core stall: requested and not yet completed
//   iomem_*               shared memory master port (valid/ready handshake)
//   zaman_asimi_o         one-cycle pulse when a transaction is aborted
//
// Configuration:
//   BELLEK_HAKEMI_ZAMAN_ASIMI_EN  when defined, a watchdog aborts a bus cycle
//   that has waited ZAMAN_ASIMI cycles without iomem_ready_i and completes it
//   to the requester with a zero read word. When undefined, bus cycles wait
//   indefinitely and zaman_asimi_o is tied to 0.
module bellek_hakemi #(
  parameter int ZAMAN_ASIMI = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ib_valid_i,
  input  logic [31:0] ib_addr_i,
  output logic        ib_ready_o,
  output logic [31:0] ib_rdata_o,
  input  logic        l1v_sec_n_i,
  input  logic        l1v_yaz_gecerli_i,
  input  logic [31:0] l1v_adr_i,
  input  logic [3:0]  l1v_veri_maske_i,
  input  logic [31:0] l1v_veri_i,
  output logic [31:0] l1v_veri_o,
  output logic        l1v_durdur_o,
  output logic        iomem_valid_o,
  input  logic        iomem_ready_i,
  output logic [3:0]  iomem_wstrb_o,
  output logic [31:0] iomem_addr_o,
  output logic [31:0] iomem_wdata_o,
  input  logic [31:0] iomem_rdata_i,
  output logic        zaman_asimi_o
);

  localparam logic [1:0] BOSTA  = 2'd0;
  localparam logic [1:0] BUYRUK = 2'd1;
  localparam logic [1:0] VERI   = 2'd2;

  logic [1:0]  durum_q, durum_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        yaz_q, yaz_d;
  // 1: the data side wins the next simultaneous request.
  logic        veri_sira_q, veri_sira_d;
  logic        ib_ready_q, ib_ready_d;
  logic [31:0] ib_rdata_q, ib_rdata_d;
  logic        done_q, done_d;
  logic [31:0] l1v_veri_q, l1v_veri_d;

  logic        ib_istek;
  logic        v_istek;
  logic        veri_sec;
  logic        bitti;
  logic [31:0] okunan;

`ifdef BELLEK_HAKEMI_ZAMAN_ASIMI_EN
  localparam logic [7:0] SINIR = 8'(ZAMAN_ASIMI);
  logic [7:0] sayac_q, sayac_d;
  logic       zaman_asimi_q, zaman_asimi_d;
`else
  logic       unused_zaman_sinir;
  assign unused_zaman_sinir = ^(8'(ZAMAN_ASIMI));
`endif

  // A side whose completion pulse is visible this cycle is not re-issued.
  assign ib_istek = ib_valid_i & ~ib_ready_q;
  assign v_istek  = ~l1v_sec_n_i & ~done_q;
  assign veri_sec = v_istek & (~ib_istek | veri_sira_q);

  always_comb begin
    durum_d     = durum_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    yaz_d       = yaz_q;
    veri_sira_d = veri_sira_q;
    ib_ready_d  = 1'b0;
    ib_rdata_d  = ib_rdata_q;
    done_d      = 1'b0;
    l1v_veri_d  = l1v_veri_q;
    bitti       = 1'b0;
    okunan      = iomem_rdata_i;
`ifdef BELLEK_HAKEMI_ZAMAN_ASIMI_EN
    sayac_d       = sayac_q;
    zaman_asimi_d = 1'b0;
`endif

    case (durum_q)
      BOSTA: begin
        if (veri_sec) begin
          durum_d     = VERI;
          adr_d       = l1v_adr_i;
          yaz_d       = l1v_yaz_gecerli_i;
          wdata_d     = l1v_yaz_gecerli_i ? l1v_veri_i : 32'd0;
          wstrb_d     = l1v_yaz_gecerli_i ? l1v_veri_maske_i : 4'b0000;
          veri_sira_d = 1'b0;
`ifdef BELLEK_HAKEMI_ZAMAN_ASIMI_EN
          sayac_d     = 8'd0;
`endif
        end else if (ib_istek) begin
          durum_d     = BUYRUK;
          adr_d       = ib_addr_i;
          yaz_d       = 1'b0;
          wdata_d     = 32'd0;
          wstrb_d     = 4'b0000;
          veri_sira_d = 1'b1;
`ifdef BELLEK_HAKEMI_ZAMAN_ASIMI_EN
          sayac_d     = 8'd0;
`endif
        end
      end
      BUYRUK, VERI: begin
        bitti = iomem_ready_i;
`ifdef BELLEK_HAKEMI_ZAMAN_ASIMI_EN
        if (!iomem_ready_i) begin
          sayac_d = sayac_q + 8'd1;
          // The abort lands on the edge that ends the ZAMAN_ASIMI-th wait cycle.
          if (sayac_d == SINIR) begin
            bitti         = 1'b1;
            okunan        = 32'd0;
            zaman_asimi_d = 1'b1;
          end
        end
`endif
      end
      default: durum_d = BOSTA;
    endcase

    if (bitti) begin
      durum_d = BOSTA;
      if (durum_q == BUYRUK) begin
        ib_ready_d = 1'b1;
        ib_rdata_d = okunan;
      end else begin
        done_d = 1'b1;
        if (!yaz_q) begin
          l1v_veri_d = okunan;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q     <= BOSTA;
      adr_q       <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'b0000;
      yaz_q       <= 1'b0;
      veri_sira_q <= 1'b1;
      ib_ready_q  <= 1'b0;
      ib_rdata_q  <= 32'd0;
      done_q      <= 1'b0;
      l1v_veri_q  <= 32'd0;
    end else begin
      durum_q     <= durum_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      yaz_q       <= yaz_d;
      veri_sira_q <= veri_sira_d;
      ib_ready_q  <= ib_ready_d;
      ib_rdata_q  <= ib_rdata_d;
      done_q      <= done_d;
      l1v_veri_q  <= l1v_veri_d;
    end
  end

`ifdef BELLEK_HAKEMI_ZAMAN_ASIMI_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sayac_q       <= 8'd0;
      zaman_asimi_q <= 1'b0;
    end else begin
      sayac_q       <= sayac_d;
      zaman_asimi_q <= zaman_asimi_d;
    end
  end
  assign zaman_asimi_o = zaman_asimi_q;
`else
  assign zaman_asimi_o = 1'b0;
`endif

  // Valid is decoded from the state so that reset drops it immediately.
  assign iomem_valid_o = (durum_q != BOSTA);
  assign iomem_addr_o  = adr_q;
  assign iomem_wdata_o = wdata_q;
  assign iomem_wstrb_o = wstrb_q;
  assign ib_ready_o    = ib_ready_q;
  assign ib_rdata_o    = ib_rdata_q;
  assign l1v_veri_o    = l1v_veri_q;
  assign l1v_durdur_o  = ~l1v_sec_n_i & ~done_q;

endmodule

// File: doc/bellek_hakemi.md
BELLEK_HAKEMI -- requirements
Module: bellek_hakemi

Interface
REQ-001 SHALL have parameter ZAMAN_ASIMI, default 255: number of cycles iomem_valid_o may wait without iomem_ready_i before abort (used only under REQ-028).
REQ-002 SHALL have port clk_i  input  1  single system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have ports ib_valid_i input 1, ib_addr_i input 32, ib_ready_o output 1, ib_rdata_o output 32: instruction-cache refill request, address, completion pulse, read word.
REQ-005 SHALL have ports l1v_sec_n_i input 1 (active-low select), l1v_yaz_gecerli_i input 1 (1 = write), l1v_adr_i input 32, l1v_veri_maske_i input 4, l1v_veri_i input 32 (write data): core data-side request.
REQ-006 SHALL have ports l1v_veri_o output 32 (read data to core), l1v_durdur_o output 1 (core stall).
REQ-007 SHALL have ports iomem_valid_o output 1, iomem_ready_i input 1, iomem_wstrb_o output 4, iomem_addr_o output 32, iomem_wdata_o output 32, iomem_rdata_i input 32: single shared memory master port.
REQ-008 SHALL have port zaman_asimi_o  output  1  one-cycle pulse on timeout abort.

Function
REQ-009 SHALL implement states BOSTA, BUYRUK, VERI.
REQ-010 In BOSTA, a pending request SHALL move the FSM to BUYRUK (ib_valid_i=1) or VERI (l1v_sec_n_i=0) on the next edge, latching address, write data, and strobe.
REQ-011 On simultaneous requests, grant SHALL alternate: the side not granted last wins; after reset, data side wins first.
REQ-012 In BUYRUK/VERI, iomem_valid_o SHALL be 1 with iomem_addr_o/wdata_o/wstrb_o stable until the cycle iomem_ready_i=1 is sampled.
REQ-013 iomem_wstrb_o SHALL equal latched l1v_veri_maske_i for data writes, 4'b0000 for data reads and all instruction fetches.
REQ-014 iomem_wdata_o SHALL be latched l1v_veri_i for data writes, 0 otherwise.
REQ-015 On the edge where iomem_ready_i=1, FSM SHALL return to BOSTA, iomem_valid_o SHALL deassert, and iomem_rdata_i SHALL be captured.
REQ-016 ib_ready_o SHALL pulse exactly one cycle, the cycle after the ready edge, with ib_rdata_o = captured word; ib_rdata_o SHALL hold until next instruction completion.
REQ-017 Data completion SHALL raise an internal one-cycle done flag the cycle after the ready edge; l1v_veri_o SHALL present captured word (reads) and hold until next data read completion; writes leave l1v_veri_o unchanged.
REQ-018 l1v_durdur_o SHALL be combinational: 1 when l1v_sec_n_i=0 and done flag=0, else 0.
REQ-019 A request SHALL NOT be re-issued in the cycle its done/ready pulse is visible; BOSTA SHALL ignore the completing side's request for that cycle.
REQ-020 Minimum transaction latency: request at cycle N, iomem_valid_o at N+1, ready at N+1 gives completion pulse at N+2.
REQ-021 Back-to-back: with both sides continuously requesting and ready=1 immediately, grants SHALL alternate I/D/I/D.
REQ-022 Requester deasserting mid-transaction SHALL NOT abort the bus cycle; the result is completed and the pulse still issued.

Reset
REQ-023 Assertion of rst_i SHALL immediately force FSM to BOSTA and iomem_valid_o, ib_ready_o, zaman_asimi_o, done flag to 0.
REQ-024 Reset SHALL clear ib_rdata_o, l1v_veri_o, iomem_addr_o, iomem_wdata_o, iomem_wstrb_o to 0 and the alternation pointer to "data next".
REQ-025 An in-flight transaction at reset SHALL be discarded with no completion pulse after release.
REQ-026 First grant SHALL be possible on the first rising edge after rst_i deasserts.

Configuration
REQ-027 Macro BELLEK_HAKEMI_ZAMAN_ASIMI_EN SHALL select the timeout watchdog.
REQ-028 With the macro defined: an 8-bit counter SHALL clear on grant and increment each cycle iomem_valid_o=1 and iomem_ready_i=0; when it reaches ZAMAN_ASIMI, the transaction SHALL abort to BOSTA, complete to the requester with read word 32'h0000_0000, and pulse zaman_asimi_o.
REQ-029 Without the macro: no counter; transactions wait indefinitely; zaman_asimi_o SHALL be constant 0.

Verification
REQ-030 Instruction fetch ib_addr_i=0x0000_1000, ready 2 cycles after valid, rdata=0x0000_0013 -> one iomem_valid_o cycle sequence, wstrb=0, ib_ready_o one-cycle pulse, ib_rdata_o=0x0000_0013.
REQ-031 Data write adr=0x2000_0004, mask=4'b0011, veri=0xAABB_CCDD -> iomem_wstrb_o=4'b0011, iomem_wdata_o=0xAABB_CCDD; l1v_durdur_o high until done cycle, then low.
REQ-032 Simultaneous I (0x100) and D read (0x200) after reset, ready immediate -> D granted first, I second, then alternation I/D persists.
REQ-033 rst_i asserted while iomem_valid_o=1 -> iomem_valid_o 0 same cycle, no ib_ready_o/done pulse after release.
REQ-034 Macro defined, ZAMAN_ASIMI=8, ready held 0 -> abort after 8 waiting cycles, zaman_asimi_o pulse, l1v_veri_o=0, durdur released; macro undefined -> valid stays high indefinitely.
